lif_array: RTL
==============

# lif_array

Parametrised array of leaky integrate-and-fire neurons, the multi-channel successor to the single fixed-width LIF cell. Each of `N_NEURONS` neurons integrates its own input current with a shift-based leak and saturating add, fires against a shared runtime threshold, and resets either to zero or by subtraction. Optionally, it enforces a refractory period. It sits between the input current source (e.g. the tile's `ui_in` / synapse logic) and spike consumers (output pins, spike counters).

## Interface
- `N_NEURONS`, default 4: number of independent neurons (1..16).
- `WIDTH`, default 8: membrane state, current and threshold width in bits.
- `LEAK_SHIFT`, default 1: leak is `state >> LEAK_SHIFT`; range 1..WIDTH-1.
- `RESET_SUBTRACT`, default 0: 0 = reset-to-zero on spike; 1 = subtract threshold.
- `REFRACT`, default 2: refractory steps after a spike (0..15); meaningful only with `LIF_REFRACTORY_EN`.
- `clk`, input, 1: sole clock, rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `step`, input, 1: advance all neurons one timestep this cycle.
- `current`, input, N_NEURONS*WIDTH: packed unsigned currents; neuron i at `[i*WIDTH +: WIDTH]`.
- `threshold`, input, WIDTH: shared unsigned firing threshold, sampled on each `step` cycle.
- `state`, output, N_NEURONS*WIDTH: registered membrane potentials, packed as `current`.
- `spike`, output, N_NEURONS: registered per-neuron spike pulse.
- `spike_any`, output, 1: OR of `spike`, combinational from registers.

## Operation
- Reset (`reset_n`=0 at a rising edge) has priority over `step`. It clears all `state` bits, `spike` and refractory counters to 0. It is legal at any cycle, including mid-refractory.
- `step`=0: `state` and refractory counters hold, and `spike` is forced to 0. A spike is a one-cycle pulse per firing step.
- `step`=1, per neuron i, with refractory counter `r`:
  - Refractory (`r` != 0; macro builds only): `state <= state >> LEAK_SHIFT`, current ignored, `r <= r-1`, `spike <= 0`.
  - Otherwise, compute `v = sat(current_i + (state >> LEAK_SHIFT))`. The sum is formed in WIDTH+1 bits and clamped to 2^WIDTH-1.
  - If `v >= threshold`: `spike <= 1`. `state <= 0` (RESET_SUBTRACT=0) or `v - threshold` (RESET_SUBTRACT=1). `r <= REFRACT`.
  - Else: `spike <= 0`, `state <= v`.
- All arithmetic is unsigned. The leak never underflows.
- `threshold` = 0 means every non-refractory step fires. In subtract mode, `state` then equals `v`.
- Neurons are fully independent, with no lateral inhibition.

## Timing
- Latency is one cycle. Effects of `current`/`threshold` sampled at the `step` edge appear on `state`/`spike` after that same edge.
- `spike[i]` is high for exactly the cycle following a firing step.
- `spike_any` has the same timing as `spike`.
- Back-to-back `step` is allowed every cycle. There is no handshake or backpressure.
- After reset deassertion, the first `step` edge uses `state`=0.

## Configuration
- `LIF_REFRACTORY_EN` defined: per-neuron counter of `$clog2(REFRACT+1)` bits (minimum 1). Refractory behaviour applies as above, and REFRACT=0 behaves as no refractory period.
- `LIF_REFRACTORY_EN` undefined: no counters are synthesised, `REFRACT` is ignored, and a neuron may fire on every step.

## Structure
- Package `lif_pkg`:
  - default width, leak and refractory constants;
  - reset-mode localparams `LIF_RESET_ZERO` = 0 and `LIF_RESET_SUB` = 1;
  - a saturating-add function.
- Sub-module `lif_neuron`: one neuron holding state, refractory counter and spike register. `lif_array` instantiates N_NEURONS copies via a generate loop, slices the packed buses and ORs the spikes.

## Test plan
Defaults unless stated: WIDTH=8, LEAK_SHIFT=1, threshold=200, `step` held 1.
- Convergence without firing: current=100 on neuron 0. `state` runs 100, 150, 175, 187, 193, 196, 198, 199, then holds at 199, and `spike[0]` never asserts.
- Threshold crossing: current=101, zero mode. `state` runs 101, 151, 176, 189, 195, 198, then fires on the 7th step (v=200): `spike[0]`=1 for one cycle, `state` returns to 0 and `spike_any`=1.
- Subtract mode: RESET_SUBTRACT=1, threshold=100, current=150. Spikes occur on steps 1, 2 and 3, with `state` = 50, 75, 87.
- Saturation: threshold=255, current=255 from `state`=255. v clamps to 255, the neuron fires, and no wrap to a small value occurs.
- Refractory: current=200, threshold=200, REFRACT=2. With `LIF_REFRACTORY_EN`, spikes occur on steps 1, 4 and 7. Without it, a spike occurs on every step.
- Control: deassert `step` mid-run, then `state` holds and `spike`=0. Assert `reset_n`=0 together with `step`=1 during refractory, then all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants and arithmetic helpers for the LIF neuron array.
// Optional feature macro used by importers: LIF_REFRACTORY_EN.
package lif_pkg;

  localparam int unsigned LIF_DEFAULT_WIDTH   = 8;
  localparam int unsigned LIF_DEFAULT_LEAK    = 1;
  localparam int unsigned LIF_DEFAULT_REFRACT = 2;

  // Reset-on-spike modes
  localparam int unsigned LIF_RESET_ZERO = 0;
  localparam int unsigned LIF_RESET_SUB  = 1;

  // Unsigned add clamped to 2^width-1; operands are zero-extended into 32 bits,
  // the sum is formed one bit wider so a carry out is never lost.
  function automatic logic [31:0] lif_sat_add(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << width) - 33'd1;
    return (sum > max_val) ? 32'(max_val) : 32'(sum);
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// Single leaky integrate-and-fire neuron: membrane state, spike register and,
// when LIF_REFRACTORY_EN is defined, a refractory down-counter.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH          = LIF_DEFAULT_WIDTH,
  parameter int unsigned LEAK_SHIFT     = LIF_DEFAULT_LEAK,
  parameter int unsigned RESET_SUBTRACT = LIF_RESET_ZERO,
  parameter int unsigned REFRACT        = LIF_DEFAULT_REFRACT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic [WIDTH-1:0] current,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] state,
  output logic             spike
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             spike_q, spike_d;
  logic [WIDTH-1:0] leaked;
  logic [31:0]      v_full;
  logic             fire;
  logic             in_refr;

`ifdef LIF_REFRACTORY_EN
  localparam int unsigned RW = (REFRACT == 0) ? 1 : $clog2(REFRACT + 1);
  logic [RW-1:0] refr_q, refr_d;
  assign in_refr = (refr_q != '0);
`else
  assign in_refr = 1'b0;
`endif

  assign leaked = state_q >> LEAK_SHIFT;
  assign v_full = lif_sat_add(32'(current), 32'(leaked), WIDTH);
  // Compare at full width so a clamped sum is never mistaken for a small one.
  assign fire   = (v_full >= 32'(threshold));

  // Next-state: hold when idle, leak-only when refractory, else integrate/fire.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    spike_d = 1'b0;
`ifdef LIF_REFRACTORY_EN
    refr_d  = refr_q;
`endif
    if (step) begin
      if (in_refr) begin
        state_d = leaked;
`ifdef LIF_REFRACTORY_EN
        refr_d  = refr_q - 1'b1;
`endif
      end else if (fire) begin
        spike_d = 1'b1;
        state_d = (RESET_SUBTRACT == LIF_RESET_SUB) ? (WIDTH'(v_full) - threshold) : '0;
`ifdef LIF_REFRACTORY_EN
        refr_d  = RW'(REFRACT);
`endif
      end else begin
        state_d = WIDTH'(v_full);
      end
    end
  end

  // State and spike registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset_n) begin
      state_q <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      spike_q <= spike_d;
    end
  end

`ifdef LIF_REFRACTORY_EN
  // Refractory counter, cleared by reset even mid-period.
  always_ff @(posedge clk) begin
    if (!reset_n) refr_q <= '0;
    else          refr_q <= refr_d;
  end
`endif

  assign state = state_q;
  assign spike = spike_q;

endmodule

// File: rtl/lif_array.sv
// Array of N_NEURONS independent LIF neurons sharing one threshold.
// Build option: define LIF_REFRACTORY_EN to add per-neuron refractory periods.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS      = 4,
  parameter int unsigned WIDTH          = LIF_DEFAULT_WIDTH,
  parameter int unsigned LEAK_SHIFT     = LIF_DEFAULT_LEAK,
  parameter int unsigned RESET_SUBTRACT = LIF_RESET_ZERO,
  parameter int unsigned REFRACT        = LIF_DEFAULT_REFRACT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       step,
  input  logic [N_NEURONS*WIDTH-1:0] current,
  input  logic [WIDTH-1:0]           threshold,
  output logic [N_NEURONS*WIDTH-1:0] state,
  output logic [N_NEURONS-1:0]       spike,
  output logic                       spike_any
);

  // Elaboration-time parameter range checks.
  if (N_NEURONS < 1 || N_NEURONS > 16) begin : g_bad_n
    $error("lif_array: N_NEURONS out of range 1..16");
  end
  if (WIDTH > 32 || LEAK_SHIFT < 1 || LEAK_SHIFT >= WIDTH) begin : g_bad_leak
    $error("lif_array: WIDTH/LEAK_SHIFT out of range");
  end
  if (REFRACT > 15 || RESET_SUBTRACT > LIF_RESET_SUB) begin : g_bad_mode
    $error("lif_array: REFRACT or RESET_SUBTRACT out of range");
  end

  // One neuron per lane, each on its own slice of the packed buses.
  for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
    lif_neuron #(
      .WIDTH         (WIDTH),
      .LEAK_SHIFT    (LEAK_SHIFT),
      .RESET_SUBTRACT(RESET_SUBTRACT),
      .REFRACT       (REFRACT)
    ) u_neuron (
      .clk      (clk),
      .reset_n  (reset_n),
      .step     (step),
      .current  (current[g*WIDTH +: WIDTH]),
      .threshold(threshold),
      .state    (state[g*WIDTH +: WIDTH]),
      .spike    (spike[g])
    );
  end

  assign spike_any = |spike;

endmodule
